// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if -- request/response bundle between the MIPS control unit
// and the multicycle multiply/divide unit.
//
// Signals:
//   start    request pulse (controller -> unit)
//   op       0 = mult, 1 = div
//   a, b     rs / rt operand values
//   uns      unsigned operation select (only with MULTDIV_UNSIGNED_EN)
//   busy     operation in progress (unit -> controller)
//   done     one-cycle completion pulse
//   div_zero one-cycle divide-by-zero exception pulse, coincident with done
//   hi, lo   HI/LO results
//
// Optional feature macro: MULTDIV_UNSIGNED_EN adds the uns signal.
interface mult_div_unit_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
`ifdef MULTDIV_UNSIGNED_EN
  logic        uns;
`endif
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

`ifdef MULTDIV_UNSIGNED_EN
  modport master (output start, op, a, b, uns,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start, op, a, b, uns,
                  output busy, done, div_zero, hi, lo);
`else
  modport master (output start, op, a, b,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start, op, a, b,
                  output busy, done, div_zero, hi, lo);
`endif
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit -- multicycle signed multiply/divide unit for mult/div.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low; clears all state and outputs
//   bus    mult_div_unit_if.slave: start/op/a/b(/uns) in,
//          busy/done/div_zero/hi/lo out
//
// Operation: IDLE -> CALC (32 iterations, one bit per cycle on operand
// magnitudes) -> FIX (sign correction, HI/LO update, done pulse) -> IDLE.
// Multiply is LSB-first shift-add; divide is MSB-first restoring division.
// A divide with b == 0 never leaves IDLE; it answers with done + div_zero.
//
// Optional feature macro: MULTDIV_UNSIGNED_EN adds bus.uns (multu/divu).
module mult_div_unit (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        op_q;
  logic [31:0] mag_a;     // mult: multiplicand; div: dividend, shifted out MSB first
  logic [31:0] mag_b;     // mult: multiplier, shifted out LSB first; div: divisor
  logic        neg_q;     // product / quotient must be negated in FIX
  logic        neg_r;     // remainder must be negated in FIX
  logic [63:0] acc;       // mult: running product; div: {remainder, quotient}
  logic        done_q, div_zero_q;
  logic [31:0] hi_q, lo_q;

  // Signedness of the incoming request. Magnitudes are 32-bit unsigned, so
  // |0x80000000| is the unsigned value 2^31 rather than a negative number.
  logic sgn;
`ifdef MULTDIV_UNSIGNED_EN
  assign sgn = ~bus.uns;
`else
  assign sgn = 1'b1;
`endif

  logic a_neg, b_neg, b_zero, start_dz, start_ok;
  assign a_neg    = sgn & bus.a[31];
  assign b_neg    = sgn & bus.b[31];
  assign b_zero   = (bus.b == '0);
  assign start_dz = (state == IDLE) && bus.start && bus.op && b_zero;
  assign start_ok = (state == IDLE) && bus.start && !(bus.op && b_zero);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = CALC;
      CALC:    if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath combinational logic.
  logic        busy_c;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        q_bit;
  logic [31:0] div_rem;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, hi_fix, lo_fix;

  always_comb begin
    busy_c    = (state != IDLE);
    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set; the 33-bit sum carries into the shift.
    mul_sum   = {1'b0, acc[63:32]} + (mag_b[0] ? {1'b0, mag_a} : 33'd0);
    // Restoring divide: bring down the next dividend bit and trial-subtract.
    div_shift = {acc[63:32], mag_a[31]};
    q_bit     = (div_shift >= {1'b0, mag_b});
    // When the subtract succeeds the true difference is below the divisor,
    // so its low 32 bits are exact.
    div_rem   = q_bit ? (div_shift[31:0] - mag_b) : div_shift[31:0];
    prod_fix  = neg_q ? -acc : acc;
    quo_fix   = neg_q ? -acc[31:0]  : acc[31:0];
    rem_fix   = neg_r ? -acc[63:32] : acc[63:32];
    hi_fix    = op_q ? rem_fix : prod_fix[63:32];
    lo_fix    = op_q ? quo_fix : prod_fix[31:0];
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      op_q       <= 1'b0;
      mag_a      <= '0;
      mag_b      <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      acc        <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_dz) begin
            done_q     <= 1'b1;
            div_zero_q <= 1'b1;
          end else if (start_ok) begin
            op_q  <= bus.op;
            mag_a <= a_neg ? -bus.a : bus.a;
            mag_b <= b_neg ? -bus.b : bus.b;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (op_q) begin
            acc   <= {div_rem, acc[30:0], q_bit};
            mag_a <= {mag_a[30:0], 1'b0};
          end else begin
            acc   <= {mul_sum, acc[31:1]};
            mag_b <= {1'b0, mag_b[31:1]};
          end
        end
        FIX: begin
          hi_q   <= hi_fix;
          lo_q   <= lo_fix;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_c;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit -- self-checking bench for mult_div_unit: directed
// corner cases plus randomized operations against an arithmetic model.
module tb_mult_div_unit;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [31:0] exp_hi, exp_lo;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; returns {hi, lo}.
  function automatic logic [63:0] model(input logic op_i, input logic [31:0] a_i,
                                        input logic [31:0] b_i, input logic uns_i);
    longint sa, sb, q, r;
    logic [63:0] res;
    if (uns_i) begin
      sa = longint'({32'd0, a_i});
      sb = longint'({32'd0, b_i});
    end else begin
      sa = longint'($signed(a_i));
      sb = longint'($signed(b_i));
    end
    if (!op_i) begin
      res = 64'(sa * sb);
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0;
      1:       v = 32'h1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'h7FFF_FFFF;
      5:       v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one request and check timing and result. inj_at >= 0 fires an
  // extra start with a different op at that many cycles after acceptance.
  task automatic run_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        input logic uns_i, input int inj_at);
    logic [63:0] exp;
    int k;
    int busy_n;
    exp = model(op_i, a_i, b_i, uns_i);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
`ifdef MULTDIV_UNSIGNED_EN
    bus.uns   = uns_i;
`endif
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    if (op_i && b_i == 32'd0) begin
      check("dz_done",  64'(bus.done), 64'd1);
      check("dz_flag",  64'(bus.div_zero), 64'd1);
      check("dz_busy",  64'(bus.busy), 64'd0);
      check("dz_hold",  {bus.hi, bus.lo}, {exp_hi, exp_lo});
      @(negedge clk);
      check("dz_fall",  64'({bus.done, bus.div_zero}), 64'd0);
      check("dz_busy2", 64'(bus.busy), 64'd0);
    end else begin
      busy_n = 0;
      while (!bus.done && k < 40) begin
        if (bus.busy) busy_n++;
        if (k == 32) check("hold_prev", {bus.hi, bus.lo}, {exp_hi, exp_lo});
        if (k == inj_at) begin
          bus.start = 1'b1;
          bus.op    = ~op_i;
          bus.a     = $urandom;
          bus.b     = $urandom;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        k++;
      end
      bus.start = 1'b0;
      check("latency",     64'(k), 64'd33);
      check("busy_cycles", 64'(busy_n), 64'd33);
      check("busy_at_done", 64'(bus.busy), 64'd0);
      check("no_dz_flag",  64'(bus.div_zero), 64'd0);
      check(op_i ? "div_result" : "mult_result", {bus.hi, bus.lo}, exp);
      exp_hi = exp[63:32];
      exp_lo = exp[31:0];
      @(negedge clk);
      check("done_fall", 64'(bus.done), 64'd0);
    end
  endtask

  initial begin
    int k;
    logic rnd_op, rnd_uns;
    n_vec = 0;
    n_err = 0;
    exp_hi = '0;
    exp_lo = '0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef MULTDIV_UNSIGNED_EN
    bus.uns   = 1'b0;
`endif
    #1;
    check("reset_outputs", 64'({bus.busy, bus.done, bus.div_zero}), 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Directed cases.
    run_op(1'b0, 32'd7,          32'hFFFF_FFFD, 1'b0, -1);
    run_op(1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 1'b0, -1);
    run_op(1'b0, 32'h8000_0000,  32'h8000_0000, 1'b0, -1);
    run_op(1'b1, 32'hFFFF_FFF9,  32'd2,         1'b0, -1);
    run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0, -1);
    run_op(1'b1, 32'd5,          32'd2,         1'b0, -1);
    run_op(1'b1, 32'd5,          32'd0,         1'b0, -1);
    run_op(1'b0, 32'h0001_2345,  32'hFFFF_0010, 1'b0, 10);

    // Reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'h1234_5678;
    bus.b     = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (k < 15) begin
      @(negedge clk);
      k++;
    end
    reset = 1'b0;
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) check("rst_no_done", 64'({bus.done, bus.busy}), 64'd0);
    end
    run_op(1'b0, 32'd3, 32'd4, 1'b0, -1);

`ifdef MULTDIV_UNSIGNED_EN
    run_op(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1, -1);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, -1);
`endif

    // Randomized operations.
    for (int i = 0; i < 20; i++) begin
      rnd_op  = 1'($urandom_range(0, 1));
      rnd_uns = 1'b0;
`ifdef MULTDIV_UNSIGNED_EN
      rnd_uns = 1'($urandom_range(0, 1));
`endif
      run_op(rnd_op, pick(), pick(), rnd_uns, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multicycle signed multiply/divide unit serving the MIPS datapath's `mult`/`div` instructions. It is the responder to the control unit's mult/div request: the controller pulses `start` with the operation and the A/B register values, waits on `busy`/`done`, then writes HI/LO from `hi`/`lo`. Divide-by-zero is reported back to the controller as a one-cycle exception flag, alongside the existing overflow and invalid-opcode exception paths.

## Interface
- No parameters; datapath width fixed at 32 bits.
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `start`  in  1  request pulse; sampled only in IDLE
- `op`  in  1  0 = mult, 1 = div; sampled with `start`
- `a`  in  32  multiplicand / dividend (rs); sampled with `start`
- `b`  in  32  multiplier / divisor (rt); sampled with `start`
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse: `hi`/`lo` valid or div-by-zero reported
- `div_zero`  out  1  one-cycle pulse together with `done`, div with `b == 0`
- `hi`  out  32  mult: product[63:32]; div: remainder
- `lo`  out  32  mult: product[31:0]; div: quotient

## Operation
- States: IDLE, CALC, FIX.
- IDLE: `start`=1 and not div-by-zero → latch magnitudes |a|, |b|, result signs, `op`; clear 64-bit accumulator; iteration counter = 0; `busy`←1; go to CALC.
- IDLE: `start`=1, `op`=1, `b`=0 → `done`←1, `div_zero`←1 next cycle; stay IDLE; `hi`/`lo` unchanged; `busy` stays 0.
- CALC: one iteration per cycle, 32 iterations (counter 0..31).
  - mult: shift-add on magnitudes, one multiplier bit per cycle, LSB first.
  - div: restoring division on magnitudes, one quotient bit per cycle, MSB first; trial subtract of 33-bit partial remainder.
  - counter = 31 → FIX.
- FIX: apply sign correction, register `hi`/`lo`, `done`←1, `busy`←0, go to IDLE.
- Arithmetic rules:
  - mult: {hi,lo} = signed 64-bit product of a×b; no overflow possible.
  - div: quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (wraps, no flag).
  - |0x80000000| is handled as the unsigned magnitude 2^31 internally (33-bit magnitudes or unsigned handling), not as a negative value.
- `start` while `busy`=1: ignored, no effect on the operation in flight.
- `hi`/`lo` hold their value from the last completed operation until the next FIX.
- Reset (asynchronous, active-low):
  - all outputs go to 0, including `hi` and `lo`; state goes to IDLE.
  - Reset mid-operation aborts the operation with no `done` pulse.

## Timing
- `start` sampled at edge E0:
  - `busy`=1 after E0.
  - CALC iterations occur on E1..E32.
  - FIX occurs at E33: `done`=1 and results valid after E33; `busy`=0 after E33.
  - `done` falls after E34.
- Latency from `start` to `done` is 33 cycles; `busy` is high for 33 cycles.
- Div-by-zero path: `done`/`div_zero` are high for exactly the one cycle after E0.
- A new `start` is accepted in the cycle `done` is high (the unit is in IDLE). Back-to-back throughput is one operation per 34 cycles.
- `done` and `div_zero` are registered; no combinational path from inputs to outputs.

## Configuration
- `MULTDIV_UNSIGNED_EN` defined:
  - adds input `uns` (1 bit), sampled with `start`.
  - When `uns`=1, operands are treated as unsigned and no sign correction is applied (`multu`/`divu`).
  - `b`=0 still raises `div_zero`.
- `MULTDIV_UNSIGNED_EN` undefined:
  - no `uns` port.
  - All operations are signed; the unsigned datapath and its muxing are not built.

## Test plan
- mult a=7, b=0xFFFFFFFD (−3) → `done` 33 cycles after `start`; hi=0xFFFFFFFF, lo=0xFFFFFFEB; `busy` high for exactly 33 cycles.
- mult a=0x7FFFFFFF, b=0x7FFFFFFF → hi=0x3FFFFFFF, lo=0x00000001. Then mult 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- div a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- div a=5, b=0 after a prior result hi=1, lo=2 → `done`=`div_zero`=1 one cycle after `start`, for exactly one cycle; hi=1, lo=2 retained; `busy` never high.
- Extra `start` with a different op at cycle 10 of a running mult is ignored, and the original result is produced at cycle 33. Assert `reset` low at cycle 15 of a second operation → `busy`, `hi`, `lo` = 0 immediately, with no `done`. After release, a new mult 3×4 gives lo=12.
- With `MULTDIV_UNSIGNED_EN`, `uns`=1:
  - divu 0xFFFFFFFF / 2 → lo=0x7FFFFFFF, hi=1.
  - multu 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE.
